// File: rtl/sobel_pkg.sv
// Shared definitions for the Sobel datapath: pixel/window geometry and the
// byte-index helper used to pack a 3x3 neighbourhood into one flat word.
package sobel_pkg;

  localparam int PIX_W   = 8;
  localparam int WIN_DIM = 3;
  localparam int WIN_PIX = WIN_DIM * WIN_DIM;
  localparam int WIN_W   = WIN_PIX * PIX_W;

  // Byte slot of window row r (0 = top) and column c (0 = left).
  function automatic int win_idx(input int r, input int c);
    return r * WIN_DIM + c;
  endfunction

endpackage

// File: rtl/sobel_line_buffer.sv
// One image-row delay line: combinational read of the addressed entry and a
// write to the same entry on the clock edge (read-before-write).
module sobel_line_buffer #(
  parameter int DEPTH  = 720,
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 10
) (
  input  logic              clock,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WIDTH-1:0]  wr_data,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: the memory has no reset; stale or uninitialised rows are never
  // emitted because the window generator gates output on row >= 2.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[addr] <= wr_data;
    end
  end

  assign rd_data = mem[addr];

endmodule

// File: rtl/sobel_window_gen.sv
// Streaming 3x3 window generator: buffers two previous rows and emits one
// packed neighbourhood per interior pixel over a valid/ready handshake.
module sobel_window_gen
  import sobel_pkg::*;
#(
  parameter int IMG_WIDTH  = 720,
  parameter int IMG_HEIGHT = 540,
  parameter int DWIDTH_IN  = PIX_W,
  parameter int DWIDTH_OUT = WIN_W
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [DWIDTH_IN-1:0]  in_data,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic [DWIDTH_OUT-1:0] out_data,
  input  logic                  out_ready,
  output logic                  frame_done
);

  localparam int COL_W = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int ROW_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);

  // One window column, index 0 = top (oldest row).
  typedef logic [WIN_DIM-1:0][DWIDTH_IN-1:0] column_t;

  logic [COL_W-1:0]      col_q, col_d;
  logic [ROW_W-1:0]      row_q, row_d;
  column_t               win0_q, win0_d, win1_q, win1_d, win2_q, win2_d;
  logic                  out_valid_q, out_valid_d;
  logic [DWIDTH_OUT-1:0] out_data_q, out_data_d;
  logic                  frame_done_q, frame_done_d;

  logic                  accept;
  logic                  emit;
  logic [DWIDTH_IN-1:0]  lb0_rd, lb1_rd;
  column_t               new_col;
  column_t               win_cols [WIN_DIM];
  logic [DWIDTH_OUT-1:0] window;

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  // lb1 delays by one row, lb0 by two: lb0 is refilled from lb1's old value.
  sobel_line_buffer #(.DEPTH(IMG_WIDTH), .WIDTH(DWIDTH_IN), .ADDR_W(COL_W)) u_lb1 (
    .clock   (clock),
    .wr_en   (accept),
    .addr    (col_q),
    .wr_data (in_data),
    .rd_data (lb1_rd)
  );

  sobel_line_buffer #(.DEPTH(IMG_WIDTH), .WIDTH(DWIDTH_IN), .ADDR_W(COL_W)) u_lb0 (
    .clock   (clock),
    .wr_en   (accept),
    .addr    (col_q),
    .wr_data (lb1_rd),
    .rd_data (lb0_rd)
  );

  always_comb begin
    new_col[0] = lb0_rd;
    new_col[1] = lb1_rd;
    new_col[2] = in_data;
    win_cols[0] = win1_q;
    win_cols[1] = win2_q;
    win_cols[2] = new_col;
    window = '0;
    for (int r = 0; r < WIN_DIM; r++) begin
      for (int c = 0; c < WIN_DIM; c++) begin
        window[win_idx(r, c)*DWIDTH_IN +: DWIDTH_IN] = win_cols[c][r];
      end
    end
  end

  // Border gate: also hides stale columns across a row wrap and stale
  // line-buffer rows after reset.
  assign emit = accept && (row_q >= ROW_W'(2)) && (col_q >= COL_W'(2));

  // NOTE: every *_d takes its hold value first, so no branch can leave one
  // unassigned and infer a latch.
  always_comb begin
    col_d        = col_q;
    row_d        = row_q;
    win0_d       = win0_q;
    win1_d       = win1_q;
    win2_d       = win2_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    frame_done_d = 1'b0;

    if (accept) begin
      win0_d = win1_q;
      win1_d = win2_q;
      win2_d = new_col;
      if (col_q == COL_LAST) begin
        col_d = '0;
        if (row_q == ROW_LAST) begin
          row_d        = '0;
          frame_done_d = 1'b1;
        end else begin
          row_d = row_q + ROW_W'(1);
        end
      end else begin
        col_d = col_q + COL_W'(1);
      end
    end

    if (out_ready) begin
      out_valid_d = 1'b0;
    end
    if (emit) begin
      out_valid_d = 1'b1;
      out_data_d  = window;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // its pre-edge inputs regardless of process ordering.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      col_q        <= '0;
      row_q        <= '0;
      win0_q       <= '0;
      win1_q       <= '0;
      win2_q       <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      frame_done_q <= 1'b0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      win0_q       <= win0_d;
      win1_q       <= win1_d;
      win2_q       <= win2_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_sobel_window_gen.sv
// Directed bench for sobel_window_gen on a 4x4 image: vector table for two
// back-to-back frames, then stall, random-handshake and mid-frame reset runs.
module tb_sobel_window_gen;
  import sobel_pkg::*;

  localparam int W      = 4;
  localparam int H      = 4;
  localparam int NPIX   = W * H;
  localparam int BUDGET = 2000;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = '0;
  logic        out_ready = 1'b0;
  logic        in_ready;
  logic        out_valid;
  logic [71:0] out_data;
  logic        frame_done;

  always #5 clock = ~clock;

  sobel_window_gen #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .DWIDTH_IN(8), .DWIDTH_OUT(72)) dut (
    .clock      (clock),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .frame_done (frame_done)
  );

  int n_vec = 0;
  int n_err = 0;
  int n_done = 0;
  logic [71:0] got_q [$];

  // Inputs change just after posedge, so the negedge view predicts the next edge.
  always @(negedge clock) begin
    if (out_valid === 1'b1 && out_ready === 1'b1) got_q.push_back(out_data);
    if (frame_done === 1'b1) n_done++;
  end

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        in_valid;
    logic [7:0]  in_data;
    logic        out_ready;
    logic        exp_valid;
    logic [71:0] exp_data;
    logic        exp_done;
  } vec_t;

  vec_t        vecs [2*NPIX];
  logic [71:0] exp_win [8];
  logic [7:0]  img [2][H][W];

  function automatic logic [71:0] model_win(input int f, input int rc, input int cc);
    logic [71:0] w;
    w = '0;
    for (int rr = 0; rr < 3; rr++)
      for (int c2 = 0; c2 < 3; c2++)
        w[win_idx(rr, c2)*8 +: 8] = img[f][rc-1+rr][cc-1+c2];
    return w;
  endfunction

  function automatic logic [7:0] p(input int idx, input int base);
    return 8'((idx / W) * 16 + (idx % W) + base);
  endfunction

  task automatic push_pixel(input logic [7:0] d);
    in_valid  = 1'b1;
    in_data   = d;
    out_ready = 1'b1;
    @(posedge clock);
    #1;
  endtask

  task automatic idle_cycle();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clock);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1);
  end

  initial begin
    int sent;
    int cycles;
    logic acc;

    // Reset state
    #2;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, 72'h0);
    check("rst_frame_done", frame_done, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;

    // Two back-to-back frames: p(r,c)=16r+c, then p+0x80
    exp_win[0] = 72'h222120121110020100;
    exp_win[1] = 72'h232221131211030201;
    exp_win[2] = 72'h323130222120121110;
    exp_win[3] = 72'h333231232221131211;
    exp_win[4] = 72'hA2A1A0929190828180;
    exp_win[5] = 72'hA3A2A1939291838281;
    exp_win[6] = 72'hB2B1B0A2A1A0929190;
    exp_win[7] = 72'hB3B2B1A3A2A1939291;
    for (int f = 0; f < 2; f++) begin
      for (int r = 0; r < H; r++) begin
        for (int c = 0; c < W; c++) begin
          int i;
          i = f * NPIX + r * W + c;
          vecs[i].in_valid  = 1'b1;
          vecs[i].in_data   = 8'(16 * r + c + 128 * f);
          vecs[i].out_ready = 1'b1;
          vecs[i].exp_valid = (r >= 2 && c >= 2);
          vecs[i].exp_data  = '0;
          if (r >= 2 && c >= 2) vecs[i].exp_data = exp_win[f*4 + (r-2)*2 + (c-2)];
          vecs[i].exp_done  = (r == H-1 && c == W-1);
        end
      end
    end

    for (int i = 0; i < 2*NPIX; i++) begin
      in_valid  = vecs[i].in_valid;
      in_data   = vecs[i].in_data;
      out_ready = vecs[i].out_ready;
      @(posedge clock);
      #1;
      check($sformatf("vec%0d_valid", i), out_valid, vecs[i].exp_valid);
      if (vecs[i].exp_valid) check($sformatf("vec%0d_data", i), out_data, vecs[i].exp_data);
      check($sformatf("vec%0d_done", i), frame_done, vecs[i].exp_done);
    end
    idle_cycle();
    check("drain_valid", out_valid, 1'b0);
    check("drain_done", frame_done, 1'b0);

    // Backpressure: hold out_ready low after the first window
    for (int i = 0; i <= 10; i++) push_pixel(p(i, 0));
    check("stall_first_valid", out_valid, 1'b1);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = p(11, 0);
    #1;
    check("stall_in_ready", in_ready, 1'b0);
    for (int k = 0; k < 4; k++) begin
      @(posedge clock);
      #1;
      check($sformatf("stall%0d_valid", k), out_valid, 1'b1);
      check($sformatf("stall%0d_data", k), out_data, exp_win[0]);
      check($sformatf("stall%0d_in_ready", k), in_ready, 1'b0);
    end
    out_ready = 1'b1;
    @(posedge clock);
    #1;
    check("resume_valid", out_valid, 1'b1);
    check("resume_data", out_data, exp_win[1]);
    push_pixel(p(12, 0));
    check("resume12_valid", out_valid, 1'b0);
    push_pixel(p(13, 0));
    check("resume13_valid", out_valid, 1'b0);
    push_pixel(p(14, 0));
    check("resume14_data", out_data, exp_win[2]);
    push_pixel(p(15, 0));
    check("resume15_data", out_data, exp_win[3]);
    check("resume15_done", frame_done, 1'b1);
    idle_cycle();

    // Random valid/ready over two frames of random pixels
    for (int f = 0; f < 2; f++)
      for (int r = 0; r < H; r++)
        for (int c = 0; c < W; c++)
          img[f][r][c] = 8'($urandom);
    got_q.delete();
    n_done = 0;
    sent   = 0;
    cycles = 0;
    while ((sent < 2*NPIX || got_q.size() < 8) && cycles < BUDGET) begin
      out_ready = 1'($urandom_range(0, 1));
      if (sent < 2*NPIX) begin
        in_valid = 1'($urandom_range(0, 1));
        in_data  = img[sent/NPIX][(sent%NPIX)/W][sent%W];
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clock);
      acc = in_valid && in_ready;
      @(posedge clock);
      #1;
      if (acc) sent++;
      cycles++;
    end
    idle_cycle();
    check("rand_budget", 1'(cycles < BUDGET), 1'b1);
    check("rand_count", got_q.size(), 8);
    for (int k = 0; k < 8; k++)
      if (k < got_q.size())
        check($sformatf("rand_win%0d", k), got_q[k], model_win(k/4, 1 + (k%4)/2, 1 + (k%4)%2));
    check("rand_frames", n_done, 2);

    // Asynchronous reset mid-frame while a window is pending
    for (int i = 0; i <= 10; i++) push_pixel(p(i, 0));
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #1;
    check("arst_pre_valid", out_valid, 1'b1);
    #1;
    reset = 1'b1;
    #1;
    check("arst_out_valid", out_valid, 1'b0);
    check("arst_out_data", out_data, 72'h0);
    check("arst_in_ready", in_ready, 1'b1);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        img[0][r][c] = p(r * W + c, 8'h40);
    got_q.delete();
    n_done = 0;
    for (int i = 0; i < NPIX; i++) push_pixel(img[0][i/W][i%W]);
    idle_cycle();
    idle_cycle();
    check("post_rst_count", got_q.size(), 4);
    for (int k = 0; k < 4; k++)
      if (k < got_q.size())
        check($sformatf("post_rst_win%0d", k), got_q[k], model_win(0, 1 + k/2, 1 + k%2));
    check("post_rst_frames", n_done, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
